// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT stage sequencer and its write-address delay line.
package ntt_pkg;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 10;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_I      = 2'd1;
    localparam logic [1:0] MODE_ADDR   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

    function automatic logic [1:0] mode_of(logic [3:0] lm, int m1, int m2);
        if (int'(lm) < m1)      return MODE_SINGLE;
        else if (int'(lm) < m2) return MODE_I;
        else                    return MODE_ADDR;
    endfunction
endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Sequencer-to-core control bus; master is the sequencer, slave the core/host side.
interface ntt_stage_sequencer_if;
    import ntt_pkg::*;
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        log_m;
    logic [CNT_W-1:0]  i;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] upper_read_address;
    logic [ADDR_W-1:0] lower_read_address;
    logic              upper_write_enable;
    logic              lower_write_enable;
    logic [ADDR_W-1:0] upper_write_address;
    logic [ADDR_W-1:0] lower_write_address;

    modport master (
        input  start,
        output busy, done, log_m, i, mode,
               upper_read_address, lower_read_address,
               upper_write_enable, lower_write_enable,
               upper_write_address, lower_write_address
    );
    modport slave (
        output start,
        input  busy, done, log_m, i, mode,
               upper_read_address, lower_read_address,
               upper_write_enable, lower_write_enable,
               upper_write_address, lower_write_address
    );
endinterface

// File: rtl/ntt_addr_delay.sv
// LAT-deep shift register carrying {valid, addr} from the read side to the writeback side.
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int LAT = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_addr
);
    logic [LAT-1:0][ADDR_W:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= {i_vld, i_addr};
            for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    assign o_vld  = r_pipe[LAT-1][ADDR_W];
    assign o_addr = r_pipe[LAT-1][ADDR_W-1:0];
endmodule

// File: rtl/ntt_stage_sequencer.sv
// Runs NUM_STAGES read/drain stages per start pulse; the drain gap guarantees each stage's
// writeback finishes before the next stage's first read.
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int LOG_WORDS   = 9,
    parameter int PIPE_LAT    = 6,
    parameter int NUM_STAGES  = 12,
    parameter int FIRST_STAGE = 0,
    parameter int MODE1_STAGE = 5,
    parameter int MODE2_STAGE = 10
) (
    input  logic clk,
    input  logic rst_n,
    ntt_stage_sequencer_if.master bus
);
    localparam int              DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((1 << LOG_WORDS) - 1);
    localparam logic [3:0]      FIRST      = 4'(FIRST_STAGE);
    localparam logic [3:0]      LAST_STAGE = 4'(FIRST_STAGE + NUM_STAGES - 1);
    localparam logic [DW-1:0]   LAST_DRAIN = DW'(PIPE_LAT - 1);

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DW-1:0]     r_dcnt;
    logic              r_rd_vld;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_log_m;
    logic [1:0]        r_mode;
    logic              w_we;
    logic [ADDR_W-1:0] w_wa;

    // r_log_m doubles as the stage register; it is only zeroed once the last stage drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dcnt   <= '0;
            r_rd_vld <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_log_m  <= '0;
            r_mode   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= S_READ;
                        r_cnt    <= '0;
                        r_rd_vld <= 1'b1;
                        r_busy   <= 1'b1;
                        r_log_m  <= FIRST;
                        r_mode   <= mode_of(FIRST, MODE1_STAGE, MODE2_STAGE);
                    end
                end
                S_READ: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state  <= S_DRAIN;
                        r_cnt    <= '0;
                        r_dcnt   <= '0;
                        r_rd_vld <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == LAST_DRAIN) begin
                        if (r_log_m == LAST_STAGE) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_log_m <= '0;
                            r_mode  <= '0;
                        end else begin
                            r_state  <= S_READ;
                            r_rd_vld <= 1'b1;
                            r_log_m  <= r_log_m + 4'd1;
                            r_mode   <= mode_of(r_log_m + 4'd1, MODE1_STAGE, MODE2_STAGE);
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    ntt_addr_delay #(.LAT(PIPE_LAT)) u_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (r_rd_vld),
        .i_addr (r_cnt[ADDR_W-1:0]),
        .o_vld  (w_we),
        .o_addr (w_wa)
    );

    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.log_m               = r_log_m;
    assign bus.i                   = r_cnt;
    assign bus.mode                = r_mode;
    assign bus.upper_read_address  = r_cnt[ADDR_W-1:0];
    assign bus.lower_read_address  = r_cnt[ADDR_W-1:0];
    assign bus.upper_write_enable  = w_we;
    assign bus.lower_write_enable  = w_we;
    assign bus.upper_write_address = w_wa;
    assign bus.lower_write_address = w_wa;
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: three parameterisations compared cycle by cycle against a
// timeline model derived from stage period, read window and write window arithmetic.
module tb_ntt_stage_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ntt_stage_sequencer_if ifa ();
    ntt_stage_sequencer_if ifb ();
    ntt_stage_sequencer_if ifc ();

    ntt_stage_sequencer #(.LOG_WORDS(3), .PIPE_LAT(4), .NUM_STAGES(3), .FIRST_STAGE(0),
                          .MODE1_STAGE(1), .MODE2_STAGE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    ntt_stage_sequencer dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    ntt_stage_sequencer #(.LOG_WORDS(3), .PIPE_LAT(1), .NUM_STAGES(3), .FIRST_STAGE(2),
                          .MODE1_STAGE(3), .MODE2_STAGE(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    wire [55:0] obs_a = {ifa.busy, ifa.done, ifa.log_m, ifa.i, ifa.mode,
                         ifa.upper_read_address, ifa.lower_read_address,
                         ifa.upper_write_enable, ifa.lower_write_enable,
                         ifa.upper_write_address, ifa.lower_write_address};
    wire [55:0] obs_b = {ifb.busy, ifb.done, ifb.log_m, ifb.i, ifb.mode,
                         ifb.upper_read_address, ifb.lower_read_address,
                         ifb.upper_write_enable, ifb.lower_write_enable,
                         ifb.upper_write_address, ifb.lower_write_address};
    wire [55:0] obs_c = {ifc.busy, ifc.done, ifc.log_m, ifc.i, ifc.mode,
                         ifc.upper_read_address, ifc.lower_read_address,
                         ifc.upper_write_enable, ifc.lower_write_enable,
                         ifc.upper_write_address, ifc.lower_write_address};

    // t = 1 is the cycle right after the edge that samples start.
    function automatic logic [55:0] model(int t, int w, int p, int n, int f, int m1, int m2);
        int rel, s, off, lm, md, ra, wa, total;
        logic bsy, dn, we;
        bsy = 0; dn = 0; we = 0; lm = 0; md = 0; ra = 0; wa = 0;
        total = n * (w + p);
        if (t >= 1 && t <= total) begin
            rel = t - 1;
            s   = rel / (w + p);
            off = rel % (w + p);
            bsy = 1;
            lm  = f + s;
            md  = (lm < m1) ? 0 : (lm < m2) ? 1 : 2;
            if (off < w) ra = off;
            if (off >= p && off < p + w) begin
                we = 1;
                wa = off - p;
            end
        end else if (t == total + 1) begin
            dn = 1;
        end
        return {bsy, dn, 4'(lm), 10'(ra), 2'(md), 9'(ra), 9'(ra), we, we, 9'(wa), 9'(wa)};
    endfunction

    task automatic test_reset();
        ifa.start = 0; ifb.start = 0; ifc.start = 0;
        rst_n = 0;
        #12;
        n_cmp++; if (obs_a !== 56'd0) begin n_bad++; $display("FAIL reset_a got=%h exp=0", obs_a); end
        n_cmp++; if (obs_b !== 56'd0) begin n_bad++; $display("FAIL reset_b got=%h exp=0", obs_b); end
        n_cmp++; if (obs_c !== 56'd0) begin n_bad++; $display("FAIL reset_c got=%h exp=0", obs_c); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_basic();
        logic [55:0] e;
        int g = int'($urandom_range(0, 5));
        for (int k = 0; k < g; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_a !== 56'd0) begin n_bad++; $display("FAIL basic_idle got=%h exp=0", obs_a); end
        end
        @(negedge clk); ifa.start = 1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            e = model(t, 8, 4, 3, 0, 1, 2);
            n_cmp++; if (obs_a !== e) begin n_bad++; $display("FAIL basic t=%0d got=%h exp=%h", t, obs_a, e); end
            ifa.start = (t <= 37) ? 1'($urandom) : 1'b0;
        end
    endtask

    task automatic test_start_hold();
        logic [55:0] e;
        int dones = 0;
        @(negedge clk); ifa.start = 1;
        for (int t = 1; t <= 80; t++) begin
            @(posedge clk); #1;
            e = (t <= 38) ? model(t, 8, 4, 3, 0, 1, 2) : model(t - 38, 8, 4, 3, 0, 1, 2);
            n_cmp++; if (obs_a !== e) begin n_bad++; $display("FAIL hold t=%0d got=%h exp=%h", t, obs_a, e); end
            if (ifa.done) dones++;
            if (t == 39) ifa.start = 0;
        end
        n_cmp++; if (dones != 2) begin n_bad++; $display("FAIL hold_dones got=%0d exp=2", dones); end
    endtask

    task automatic test_reset_mid();
        logic [55:0] e;
        @(negedge clk); ifa.start = 1;
        for (int t = 1; t <= 15; t++) begin
            @(posedge clk); #1;
            e = model(t, 8, 4, 3, 0, 1, 2);
            n_cmp++; if (obs_a !== e) begin n_bad++; $display("FAIL rstmid t=%0d got=%h exp=%h", t, obs_a, e); end
            ifa.start = 0;
        end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (obs_a !== 56'd0) begin n_bad++; $display("FAIL rstmid_async got=%h exp=0", obs_a); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_a !== 56'd0) begin n_bad++; $display("FAIL rstmid_after k=%0d got=%h exp=0", k, obs_a); end
        end
    endtask

    task automatic test_default();
        logic [55:0] e;
        int max_i = 0;
        @(negedge clk); ifb.start = 1;
        for (int t = 1; t <= 6220; t++) begin
            @(posedge clk); #1;
            e = model(t, 512, 6, 12, 0, 5, 10);
            n_cmp++; if (obs_b !== e) begin n_bad++; $display("FAIL default t=%0d got=%h exp=%h", t, obs_b, e); end
            if (int'(ifb.i) > max_i) max_i = int'(ifb.i);
            ifb.start = 1'($urandom);
            if (t >= 6216) ifb.start = 0;
        end
        n_cmp++; if (max_i != 511) begin n_bad++; $display("FAIL default_max_i got=%0d exp=511", max_i); end
    endtask

    task automatic test_pipe1();
        logic [55:0] e;
        @(negedge clk); ifc.start = 1;
        for (int t = 1; t <= 32; t++) begin
            @(posedge clk); #1;
            e = model(t, 8, 1, 3, 2, 3, 4);
            n_cmp++; if (obs_c !== e) begin n_bad++; $display("FAIL pipe1 t=%0d got=%h exp=%h", t, obs_c, e); end
            ifc.start = 0;
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] e;
        @(negedge clk); ifc.start = 1;
        for (int t = 1; t <= 62; t++) begin
            @(posedge clk); #1;
            e = (t <= 29) ? model(t, 8, 1, 3, 2, 3, 4) : model(t - 29, 8, 1, 3, 2, 3, 4);
            n_cmp++; if (obs_c !== e) begin n_bad++; $display("FAIL b2b t=%0d got=%h exp=%h", t, obs_c, e); end
            ifc.start = (t == 29);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_hold();
        test_reset_mid();
        test_default();
        test_pipe1();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
